heart_model: RTL and testbench

HEART_MODEL -- requirements
Module: heart_model

---
 rtl/heart_pkg.sv | 24 ++
 rtl/heart_timer.sv | 54 +++++
 rtl/heart_model.sv | 182 ++++++++++++++++++
 tb/tb_heart_model.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/heart_pkg.sv
// -----------------------------------------------------------------------------
// heart_pkg -- shared types and default intervals for the heart_model block.
//
// Contents:
//   vstate_e   ventricular FSM state (READY=0, COND=1, REFR=2), the encoding
//              presented on heart_model.vstate
//   DEF_*      default interval and width constants used as parameter defaults
// -----------------------------------------------------------------------------
package heart_pkg;

  typedef enum logic [1:0] {
    V_READY = 2'd0,
    V_COND  = 2'd1,
    V_REFR  = 2'd2
  } vstate_e;

  localparam int DEF_W         = 16;
  localparam int DEF_A_PERIOD  = 100;
  localparam int DEF_AV_DELAY  = 20;
  localparam int DEF_V_ESCAPE  = 150;
  localparam int DEF_A_REFRACT = 30;
  localparam int DEF_V_REFRACT = 40;

endpackage : heart_pkg

// File: rtl/heart_timer.sv
// -----------------------------------------------------------------------------
// heart_timer -- W-bit interval counter with synchronous clear, synchronous
// load and a terminal-count compare.
//
// Parameters:
//   W     counter width
//   DOWN  0: count up when enabled, 1: count down when enabled
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset, counter -> 0
//   i_clr       synchronous clear (highest priority)
//   i_load      synchronous load of i_load_val
//   i_load_val  value loaded by i_load
//   i_en        count enable (lowest priority)
//   i_term_val  terminal value compared against the current count
//   o_count     current count
//   o_term      1 while o_count == i_term_val
// -----------------------------------------------------------------------------
module heart_timer #(
  parameter int W    = 16,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term_val,
  output logic [W-1:0] o_count,
  output logic         o_term
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= DOWN ? (r_count - W'(1)) : (r_count + W'(1));
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == i_term_val);

endmodule : heart_timer

// File: rtl/heart_model.sv
// -----------------------------------------------------------------------------
// heart_model -- cycle-based two-chamber heart model for pacemaker testing.
//
// The atrium beats intrinsically every A_PERIOD cycles unless paced (pa) after
// its refractory window. Each atrial depolarization seen in READY starts an AV
// conduction delay that ends in an intrinsic ventricular beat; the ventricle
// also escapes on its own after V_ESCAPE cycles, and can be paced (pv). After
// any ventricular depolarization it is refractory for V_REFRACT cycles.
//
// Parameters: W, A_PERIOD, AV_DELAY (>=1), V_ESCAPE, A_REFRACT (<A_PERIOD),
//             V_REFRACT (<V_ESCAPE)
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   pa        atrial pace pulse
//   pv        ventricular pace pulse
//   av_block  (only with HEART_MODEL_AV_BLOCK_EN) 1 = suppress AV conduction
//   sa        intrinsic atrial sense, one-cycle pulse
//   sv        intrinsic ventricular sense, one-cycle pulse
//   vstate    ventricular state (READY=0, COND=1, REFR=2)
//
// Configuration macro: HEART_MODEL_AV_BLOCK_EN adds the av_block input.
// -----------------------------------------------------------------------------
module heart_model
  import heart_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int A_PERIOD  = DEF_A_PERIOD,
  parameter int AV_DELAY  = DEF_AV_DELAY,
  parameter int V_ESCAPE  = DEF_V_ESCAPE,
  parameter int A_REFRACT = DEF_A_REFRACT,
  parameter int V_REFRACT = DEF_V_REFRACT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pa,
  input  logic       pv,
`ifdef HEART_MODEL_AV_BLOCK_EN
  input  logic       av_block,
`endif
  output logic       sa,
  output logic       sv,
  output logic [1:0] vstate
);

  localparam logic [W-1:0] A_LAST  = W'(A_PERIOD - 1);
  localparam logic [W-1:0] A_REFR  = W'(A_REFRACT);
  localparam logic [W-1:0] AV_LOAD = W'(AV_DELAY - 1);
  localparam logic [W-1:0] V_LAST  = W'(V_ESCAPE - 1);
  localparam logic [W-1:0] VR_LAST = W'(V_REFRACT - 1);

  vstate_e      r_state;
  vstate_e      w_next;
  logic         r_sa;
  logic         r_sv;

  logic [W-1:0] w_ta;
  logic         w_a_term;
  logic         w_a_pace;
  logic         w_a_depol;

  logic [W-1:0] w_tv;
  logic         w_tv_escape;
  logic         w_v_depol;
  logic         w_v_intr;

  logic         w_cond_load;
  logic         w_cond_zero;
  logic [W-1:0] w_cond_count_unused;
  logic         w_cond_en;

`ifdef HEART_MODEL_AV_BLOCK_EN
  assign w_cond_en = ~av_block;
`else
  assign w_cond_en = 1'b1;
`endif

  // ---------------------------------------------------------------- atrium
  // A pace accepted on the intrinsic terminal cycle still counts as paced, so
  // sa is only raised for an unpaced terminal count.
  assign w_a_pace  = pa && (w_ta >= A_REFR);
  assign w_a_depol = w_a_term || w_a_pace;

  heart_timer #(.W(W), .DOWN(1'b0)) u_ta (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (w_a_depol),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (1'b1),
    .i_term_val (A_LAST),
    .o_count    (w_ta),
    .o_term     (w_a_term)
  );

  // ------------------------------------------------------------- ventricle
  // tv keeps counting through REFR, so the escape interval is measured from
  // the last ventricular depolarization, not from the return to READY.
  heart_timer #(.W(W), .DOWN(1'b0)) u_tv (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (w_v_depol),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (1'b1),
    .i_term_val (V_LAST),
    .o_count    (w_tv),
    .o_term     (w_tv_escape)
  );

  // Conduction counter: only the zero compare drives the FSM. It is cleared on
  // every ventricular depolarization so it never decrements past zero.
  heart_timer #(.W(W), .DOWN(1'b1)) u_cond (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (w_v_depol),
    .i_load     (w_cond_load),
    .i_load_val (AV_LOAD),
    .i_en       (r_state == V_COND),
    .i_term_val ('0),
    .o_count    (w_cond_count_unused),
    .o_term     (w_cond_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= V_READY;
    end else begin
      r_state <= w_next;
    end
  end

  // Priority in READY/COND: pace > intrinsic ventricular event > conduction.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    w_next      = r_state;
    w_v_depol   = 1'b0;
    w_v_intr    = 1'b0;
    w_cond_load = 1'b0;
    unique case (r_state)
      V_READY, V_COND: begin
        if (pv) begin
          w_v_depol = 1'b1;
          w_next    = V_REFR;
        end else if (w_tv_escape || ((r_state == V_COND) && w_cond_zero)) begin
          w_v_depol = 1'b1;
          w_v_intr  = 1'b1;
          w_next    = V_REFR;
        end else if ((r_state == V_READY) && w_a_depol && w_cond_en) begin
          w_cond_load = 1'b1;
          w_next      = V_COND;
        end
      end
      V_REFR: begin
        if (w_tv == VR_LAST) begin
          w_next = V_READY;
        end
      end
      default: begin
        w_next = V_READY;
      end
    endcase
  end

  // ------------------------------------------------------------- outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sa <= 1'b0;
      r_sv <= 1'b0;
    end else begin
      r_sa <= w_a_term && !w_a_pace;
      r_sv <= w_v_intr;
    end
  end

  assign sa     = r_sa;
  assign sv     = r_sv;
  assign vstate = r_state;

endmodule : heart_model

// File: tb/tb_heart_model.sv
// -----------------------------------------------------------------------------
// tb_heart_model -- self-checking bench for heart_model (default parameters).
// Cycle numbers count rising edges since reset release; outputs are sampled
// 1 time unit after each rising edge. Expected sa/sv pulse cycles are pushed
// into queues when a scenario starts and popped as the DUT pulses.
// Define HEART_MODEL_AV_BLOCK_EN to also exercise the av_block input.
// -----------------------------------------------------------------------------
module tb_heart_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       pa;
  logic       pv;
  logic       sa;
  logic       sv;
  logic [1:0] vstate;
`ifdef HEART_MODEL_AV_BLOCK_EN
  logic       av_block;
`endif

  heart_model dut (
    .clk      (clk),
    .rst      (rst),
    .pa       (pa),
    .pv       (pv),
`ifdef HEART_MODEL_AV_BLOCK_EN
    .av_block (av_block),
`endif
    .sa       (sa),
    .sv       (sv),
    .vstate   (vstate)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    pa_at;   // edge at which pa is sampled high (-1: none)
    int    pv_at;   // edge at which pv is sampled high (-1: none)
    int    run;     // cycles to simulate
    int    sa_at[3];
    int    sv_at[3];
  } vec_t;

  vec_t vecs[9];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pa_edge  = -1;
  int   pv_edge  = -1;
  int   sa_q[$];
  int   sv_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock: drive pace inputs for the coming edge, then sample outputs.
  task automatic step();
    int exp;
    pa = (cyc + 1 == pa_edge);
    pv = (cyc + 1 == pv_edge);
    @(posedge clk);
    #1;
    cyc++;
    if (sa) begin
      exp = -1;
      if (sa_q.size() != 0) exp = sa_q.pop_front();
      check("sa_time", cyc, exp);
    end
    if (sv) begin
      exp = -1;
      if (sv_q.size() != 0) exp = sv_q.pop_front();
      check("sv_time", cyc, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pa  = 1'b0;
    pv  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sa", int'(sa), 0);
    check("rst_sv", int'(sv), 0);
    check("rst_vstate", int'(vstate), 0);
    rst     = 1'b1;
    cyc     = 0;
    pa_edge = -1;
    pv_edge = -1;
    sa_q.delete();
    sv_q.delete();
  endtask

  task automatic finish_scenario(input string name);
    check({name, "_sa_missing"}, sa_q.size(), 0);
    check({name, "_sv_missing"}, sv_q.size(), 0);
    sa_q.delete();
    sv_q.delete();
    pa_edge = -1;
    pv_edge = -1;
  endtask

  initial begin
    rst = 1'b0;
    pa  = 1'b0;
    pv  = 1'b0;
`ifdef HEART_MODEL_AV_BLOCK_EN
    av_block = 1'b0;
`endif

    //            name            pa    pv   run   sa cycles          sv cycles
    vecs[0] = '{"intrinsic",     -1,   -1,  330, '{100, 200, 300}, '{120, 220, 320}};
    vecs[1] = '{"pa_ta50",       51,   -1,  280, '{151, 251,  -1}, '{ 71, 171, 271}};
    vecs[2] = '{"pa_ta10",       11,   -1,  130, '{100,  -1,  -1}, '{120,  -1,  -1}};
    vecs[3] = '{"pa_ta29",       30,   -1,  130, '{100,  -1,  -1}, '{120,  -1,  -1}};
    vecs[4] = '{"pa_ta30",       31,   -1,  160, '{131,  -1,  -1}, '{ 51, 151,  -1}};
    vecs[5] = '{"pa_on_term",   100,   -1,  230, '{200,  -1,  -1}, '{120, 220,  -1}};
    vecs[6] = '{"pv_cond5",      -1,  105,  230, '{100, 200,  -1}, '{220,  -1,  -1}};
    vecs[7] = '{"pv_vs_cond",    -1,  120,  230, '{100, 200,  -1}, '{220,  -1,  -1}};
    vecs[8] = '{"a_in_refr",     -1,   90,  230, '{100, 200,  -1}, '{220,  -1,  -1}};

    for (int i = 0; i < 9; i++) begin
      do_reset();
      pa_edge = vecs[i].pa_at;
      pv_edge = vecs[i].pv_at;
      for (int j = 0; j < 3; j++) begin
        if (vecs[i].sa_at[j] >= 0) sa_q.push_back(vecs[i].sa_at[j]);
        if (vecs[i].sv_at[j] >= 0) sv_q.push_back(vecs[i].sv_at[j]);
      end
      for (int k = 0; k < vecs[i].run; k++) step();
      finish_scenario(vecs[i].name);
    end

    // pv five cycles into COND: REFR for exactly 40 cycles, then READY.
    do_reset();
    pv_edge = 105;
    sa_q.push_back(100);
    for (int k = 0; k < 150; k++) begin
      int exp_vs;
      step();
      if (cyc >= 98) begin
        exp_vs = (cyc < 100) ? 0 : (cyc < 105) ? 1 : (cyc < 145) ? 2 : 0;
        check("vstate_pv_cond", int'(vstate), exp_vs);
      end
    end
    finish_scenario("vstate_seq");

    // Asynchronous reset in COND while sa is high, then restart from zero.
    do_reset();
    sa_q.push_back(100);
    for (int k = 0; k < 100; k++) step();
    check("pre_rst_sa", int'(sa), 1);
    check("pre_rst_vstate", int'(vstate), 1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_sa", int'(sa), 0);
    check("async_rst_sv", int'(sv), 0);
    check("async_rst_vstate", int'(vstate), 0);
    finish_scenario("pre_rst");
    repeat (3) @(posedge clk);
    #1;
    check("hold_rst_vstate", int'(vstate), 0);
    rst = 1'b1;
    cyc = 0;
    sa_q.push_back(100);
    sv_q.push_back(120);
    for (int k = 0; k < 125; k++) step();
    finish_scenario("post_rst");

`ifdef HEART_MODEL_AV_BLOCK_EN
    // AV block: atrium keeps its rhythm, ventricle only escapes.
    av_block = 1'b1;
    do_reset();
    sa_q.push_back(100);
    sa_q.push_back(200);
    sa_q.push_back(300);
    sa_q.push_back(400);
    sv_q.push_back(150);
    sv_q.push_back(300);
    sv_q.push_back(450);
    for (int k = 0; k < 460; k++) step();
    finish_scenario("av_block");
    av_block = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_heart_model
